// File: rtl/ai_player.sv
// Computer opponent for the tug-of-war game.
// A prescaled tick clocks a 10-bit LFSR. On each tick in IDLE the pre-advance LFSR
// value is compared against the difficulty threshold to decide whether to "press".
// A press holds for HOLD_TICKS ticks, then is forced low for RELEASE_TICKS ticks.
module ai_player #(
    parameter int DIV_WIDTH     = 20,
    parameter int HOLD_TICKS    = 2,
    parameter int RELEASE_TICKS = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [8:0] i_difficulty,
    output logic       o_press,
    output logic       o_pulse,
    output logic [9:0] o_lfsr_q
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESS   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [3:0] C_HOLD = 4'(HOLD_TICKS);
    localparam logic [3:0] C_REL  = 4'(RELEASE_TICKS);

    logic [DIV_WIDTH-1:0] r_div;
    logic [9:0]           r_lfsr;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    logic                 r_pulse;
    logic                 w_pulse_nxt;
    logic                 w_tick;
    logic                 w_hit;

    // Tick fires during the last count of each prescaler period.
    assign w_tick = &r_div;

    // Threshold compare uses the LFSR value before this tick's advance.
    assign w_hit = i_enable & ({1'b0, i_difficulty} > r_lfsr);

    // Free-running prescaler; wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_div <= '0;
        else          r_div <= r_div + 1'b1;
    end

    // XNOR LFSR (taps 10,7) advances on every tick; all-ones is unreachable from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_lfsr <= '0;
        else if (w_tick) r_lfsr <= {r_lfsr[8:0], ~(r_lfsr[9] ^ r_lfsr[6])};
    end

    // State register with tick counter and start-of-press strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // Next-state logic: press on a hit, hold/release by tick count, abort hold when disabled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && w_hit) begin
                    w_state_nxt = S_PRESS;
                    w_cnt_nxt   = C_HOLD;
                    w_pulse_nxt = 1'b1;
                end
            end
            S_PRESS: begin
                if (!i_enable) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = C_REL;
                end else if (w_tick) begin
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_RELEASE;
                        w_cnt_nxt   = C_REL;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            S_RELEASE: begin
                // The tick that ends RELEASE never starts a new press.
                if (w_tick) begin
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode directly from registers so reset drops them immediately.
    always_comb begin
        o_press  = (r_state == S_PRESS);
        o_pulse  = r_pulse;
        o_lfsr_q = r_lfsr;
    end

endmodule

// File: tb/tb_ai_player.sv
// Directed bench for ai_player with DIV_WIDTH=2 (tick every 4 clocks), hold/release = 2 ticks.
// Cycle k means 1 time unit after the k-th rising edge following reset release.
module tb_ai_player;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [8:0] diff = '0;
    logic       press, pulse;
    logic [9:0] lfsr;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ai_player #(.DIV_WIDTH(2), .HOLD_TICKS(2), .RELEASE_TICKS(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (en),
        .i_difficulty (diff),
        .o_press      (press),
        .o_pulse      (pulse),
        .o_lfsr_q     (lfsr)
    );

    // Simple button front end: registered rising-edge detector on press.
    logic b_prev, b_set;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_prev <= 1'b0;
            b_set  <= 1'b0;
        end else begin
            b_prev <= press;
            b_set  <= press & ~b_prev;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] nx(input logic [9:0] v);
        return {v[8:0], ~(v[9] ^ v[6])};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Timing of the first press after reset with difficulty=511, enable=1.
    task automatic s2_timing(input string tag);
        int rises, pulses, orphan;
        logic prev;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 3)  chk({tag, "_k3_press"}, press, 0);
            if (k == 4) begin
                chk({tag, "_k4_press"}, press, 1);
                chk({tag, "_k4_pulse"}, pulse, 1);
                chk({tag, "_k4_lfsr"}, lfsr, 1);
            end
            if (k == 5) begin
                chk({tag, "_k5_pulse"}, pulse, 0);
                chk({tag, "_k5_press"}, press, 1);
            end
            if (k == 11) chk({tag, "_k11_press"}, press, 1);
            if (k == 12) begin
                chk({tag, "_k12_press"}, press, 0);
                chk({tag, "_k12_pulse"}, pulse, 0);
            end
            if (k == 20) chk({tag, "_k20_press"}, press, 0);
        end
        rises = 0; pulses = 0; orphan = 0; prev = press;
        for (int k = 0; k < 200; k++) begin
            step();
            if (press && !prev) rises++;
            if (pulse) begin
                pulses++;
                if (!(press && !prev)) orphan++;
            end
            prev = press;
        end
        chk({tag, "_repress"}, int'(rises >= 1), 1);
        chk({tag, "_pulse_per_rise"}, pulses, rises);
        chk({tag, "_orphan_pulse"}, orphan, 0);
    endtask

    int tbl[9] = '{0, 1, 3, 7, 15, 31, 63, 127, 254};

    initial begin
        logic [9:0] m, m_prev;
        int bad, lock, act, zeros, found;
        int pulses, elig, bad_align, bad_thr, bad_w, bad_gap, bad_btn;
        int start, last_fall;
        logic have_fall, prev_press, prev_pulse;

        // Scenario 1: reset state, LFSR sequence and period, difficulty 0 never presses
        rst_n = 1'b0; diff = 9'd0; en = 1'b1;
        @(negedge clk);
        chk("rst_press", press, 0);
        chk("rst_pulse", pulse, 0);
        chk("rst_lfsr", lfsr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m = '0; bad = 0; lock = 0; act = 0; zeros = 0;
        for (int k = 1; k <= 4092; k++) begin
            step();
            if (k % 4 == 0) m = nx(m);
            if (lfsr !== m) bad++;
            if (lfsr == 10'h3FF) lock++;
            if (press || pulse) act++;
            if (k % 4 == 0 && k / 4 <= 8) chk($sformatf("s1_seq%0d", k / 4), lfsr, tbl[k / 4]);
            if (k >= 4 && k < 4092 && lfsr == 10'd0) zeros++;
        end
        chk("s1_lfsr_track", bad, 0);
        chk("s1_lockup", lock, 0);
        chk("s1_no_press", act, 0);
        chk("s1_early_zero", zeros, 0);
        chk("s1_period", lfsr, 0);

        // Scenario 2: aggressive opponent press timing
        diff = 9'd511; en = 1'b1;
        apply_reset();
        s2_timing("s2");

        // Scenario 3: enable drop aborts press, holds off, then resumes
        apply_reset();
        for (int k = 1; k <= 5; k++) step();
        chk("s3_pre_press", press, 1);
        en = 1'b0;
        step();
        chk("s3_drop_press", press, 0);
        chk("s3_drop_pulse", pulse, 0);
        act = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (press || pulse) act++;
        end
        chk("s3_disabled_quiet", act, 0);
        en = 1'b1;
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            step();
            if (pulse) found = 1;
        end
        chk("s3_resume", found, 1);

        // Scenario 4: asynchronous reset mid-press
        apply_reset();
        for (int k = 1; k <= 4; k++) step();
        chk("s4_pre_pulse", pulse, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s4_async_press", press, 0);
        chk("s4_async_pulse", pulse, 0);
        chk("s4_async_lfsr", lfsr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s2_timing("s4");

        // Scenarios 5/6: threshold 200 over a full LFSR period, with button edge detector
        diff = 9'd200; en = 1'b1;
        apply_reset();
        m = '0; m_prev = '0;
        pulses = 0; elig = 0; bad_align = 0; bad_thr = 0; bad_w = 0; bad_gap = 0; bad_btn = 0;
        start = 0; last_fall = 0; have_fall = 1'b0; prev_press = 1'b0; prev_pulse = 1'b0;
        for (int k = 1; k <= 4092; k++) begin
            step();
            if (k % 4 == 0) begin
                m_prev = m;
                m = nx(m);
                if (m_prev < 10'd200) elig++;
            end
            if (pulse) begin
                pulses++;
                if (k % 4 != 0) bad_align++;
                else if (m_prev >= 10'd200) bad_thr++;
            end
            if (press && !prev_press) begin
                start = k;
                if (have_fall && (k - last_fall) < 12) bad_gap++;
            end
            if (!press && prev_press) begin
                if (k - start != 8) bad_w++;
                last_fall = k;
                have_fall = 1'b1;
            end
            if (b_set !== prev_pulse) bad_btn++;
            prev_press = press;
            prev_pulse = pulse;
        end
        chk("s5_some_pulses", int'(pulses > 0), 1);
        chk("s5_pulses_le_elig", int'(pulses <= elig), 1);
        chk("s5_pulse_on_tick", bad_align, 0);
        chk("s5_threshold", bad_thr, 0);
        chk("s5_press_width", bad_w, 0);
        chk("s5_release_gap", bad_gap, 0);
        chk("s6_button_align", bad_btn, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
